// File: rtl/out_port_uart.sv
// Word-to-serial output port: a small word FIFO feeding an 8N1 transmitter that
// sends each 16-bit word as two bytes, high byte first, with no gap between them.
module out_port_uart #(
   parameter int DATA_WIDTH   = 16,
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  ld_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  full_o,
   output logic                  overflow_o
);

   // state | meaning
   // IDLE  | line high, waiting for a word in the FIFO
   // START | start bit (line low) for the selected byte
   // DATA  | eight data bits, LSB first
   // STOP  | stop bit (line high); then next byte or back to IDLE
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] head;
   logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                  overflow_q, overflow_d;
   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2:0]            bit_q, bit_d;
   logic                  sel_q, sel_d;
   logic [15:0]           shreg_q, shreg_d;
   logic                  tx_q, tx_d;
   logic                  empty, full, push, pop, bit_end;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push    = ld_i & ~full;
   assign pop     = (state_q == IDLE) & ~empty;
   assign bit_end = (cnt_q == CNT_LAST);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d = overflow_q | (ld_i & full);
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sel_d   = sel_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      unique case (state_q)
         IDLE: begin
            tx_d  = 1'b1;
            cnt_d = '0;
            if (!empty) begin
               // bytes swapped so a plain right shift sends high byte first
               shreg_d = {head[7:0], head[15:8]};
               sel_d   = 1'b0;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shreg_q[0];
            end
         end
         DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shreg_q[1];
               end
            end
         end
         STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               if (!sel_q) begin
                  sel_d   = 1'b1;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         sel_q      <= 1'b0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sel_q      <= sel_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
      end
   end

   assign tx_o       = tx_q;
   assign busy_o     = ~((state_q == IDLE) & empty);
   assign full_o     = full;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_out_port_uart.sv
// Bench for out_port_uart: word-queue/timing reference model plus a mid-bit
// sampling line receiver; directed scenarios followed by random strobes.
module tb_out_port_uart;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int WORD  = 20 * CPB;

   logic        clk_i = 1'b0, reset_ni = 1'b0, ld_i = 1'b0;
   logic [15:0] data_i = '0;
   logic        tx_o, busy_o, full_o, overflow_o;

   always #5 clk_i = ~clk_i;

   out_port_uart #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .ld_i(ld_i),
      .tx_o(tx_o), .busy_o(busy_o), .full_o(full_o), .overflow_o(overflow_o)
   );

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;

   // reference model: queue of words, transmitter free every WORD+1 edges
   logic [15:0] mq[$];
   logic [15:0] exp_w[$];
   int  m_idle_edge = 0, m_next_pop = 0;
   bit  m_busy = 0, m_full = 0, m_ovf = 0;

   always @(posedge clk_i or negedge reset_ni) begin
      int pre;
      if (!reset_ni) begin
         mq.delete();
         cyc = 0; m_idle_edge = 0; m_next_pop = 0;
         m_busy = 0; m_full = 0; m_ovf = 0;
      end else begin
         cyc = cyc + 1;
         pre = mq.size();
         if (cyc >= m_next_pop && pre > 0) begin
            exp_w.push_back(mq.pop_front());
            m_idle_edge = cyc + WORD;
            m_next_pop  = cyc + WORD + 1;
         end
         if (ld_i) begin
            if (pre < DEPTH) mq.push_back(data_i);
            else m_ovf = 1;
         end
         m_busy = (cyc < m_idle_edge) || (mq.size() != 0);
         m_full = (mq.size() == DEPTH);
      end
   end

   // line receiver, samples mid-bit
   logic [7:0] rx_q[$];
   int  rx_t[$];
   int  frame_err = 0;
   bit  rx_act = 0;
   int  rx_cnt = 0;
   logic [9:0] rx_bits;

   always @(negedge clk_i or negedge reset_ni) begin
      if (!reset_ni) rx_act = 0;
      else if (!rx_act) begin
         if (tx_o === 1'b0) begin
            rx_act = 1; rx_cnt = 0; rx_t.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % CPB == CPB / 2) begin
            rx_bits[rx_cnt / CPB] = tx_o;
            if (rx_cnt / CPB == 9) begin
               rx_act = 0;
               if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) frame_err++;
               rx_q.push_back(rx_bits[8:1]);
            end
         end
      end
   end

   task automatic clear_logs();
      rx_q.delete(); rx_t.delete(); exp_w.delete(); frame_err = 0;
   endtask

   task automatic do_reset();
      ld_i = 0; reset_ni = 0;
      repeat (3) @(negedge clk_i);
      reset_ni = 1;
      clear_logs();
      @(negedge clk_i);
   endtask

   task automatic strobe(input logic [15:0] w);
      ld_i = 1; data_i = w;
      @(negedge clk_i);
      ld_i = 0;
   endtask

   task automatic test_reset();
      ld_i = 0; reset_ni = 0;
      #13;
      n_cmp++;
      if ({tx_o, busy_o, full_o, overflow_o} !== 4'b1000) begin
         n_bad++; $display("FAIL reset_hold: got %b expected 1000", {tx_o, busy_o, full_o, overflow_o});
      end
      @(negedge clk_i); reset_ni = 1;
      repeat (2) @(negedge clk_i);
      n_cmp++;
      if ({tx_o, busy_o, full_o, overflow_o} !== 4'b1000) begin
         n_bad++; $display("FAIL reset_release: got %b expected 1000", {tx_o, busy_o, full_o, overflow_o});
      end
      clear_logs();
   endtask

   task automatic test_single();
      int t_fall;
      strobe(16'hA55A);
      n_cmp++;
      if ({busy_o, tx_o} !== 2'b11) begin
         n_bad++; $display("FAIL single_push: busy,tx got %b expected 11", {busy_o, tx_o});
      end
      @(negedge clk_i);
      n_cmp++;
      if (tx_o !== 1'b0) begin
         n_bad++; $display("FAIL single_latency: tx got %b expected 0", tx_o);
      end
      t_fall = cyc;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if ({busy_o, full_o} !== {m_busy, m_full}) begin
            n_bad++; $display("FAIL single_flags: got %b expected %b", {busy_o, full_o}, {m_busy, m_full});
         end
         if (busy_o === 1'b0) break;
      end
      n_cmp++;
      if (cyc - t_fall !== WORD) begin
         n_bad++; $display("FAIL single_busy_len: got %0d expected %0d", cyc - t_fall, WORD);
      end
      n_cmp++;
      if (rx_q.size() !== 2) begin
         n_bad++; $display("FAIL single_rx_count: got %0d expected 2", rx_q.size());
      end else if ({rx_q[0], rx_q[1]} !== 16'hA55A || frame_err !== 0) begin
         n_bad++; $display("FAIL single_rx: got %h%h err %0d expected a55a err 0", rx_q[0], rx_q[1], frame_err);
      end
      n_cmp++;
      if (rx_t.size() !== 2 || rx_t[1] - rx_t[0] !== 10 * CPB) begin
         n_bad++; $display("FAIL single_byte_gap: got %0d starts expected 2 starts 40 apart", rx_t.size());
      end
   endtask

   task automatic test_back_to_back();
      int t_fall;
      do_reset();
      ld_i = 1; data_i = 16'h0102;
      @(negedge clk_i);
      data_i = 16'h0304;
      @(negedge clk_i);
      ld_i = 0;
      n_cmp++;
      if (tx_o !== 1'b0) begin
         n_bad++; $display("FAIL b2b_start: tx got %b expected 0", tx_o);
      end
      t_fall = cyc;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if ({busy_o, full_o} !== {m_busy, m_full}) begin
            n_bad++; $display("FAIL b2b_flags: got %b expected %b", {busy_o, full_o}, {m_busy, m_full});
         end
         if (busy_o === 1'b0) break;
      end
      n_cmp++;
      if (cyc - t_fall !== 2 * WORD + 1) begin
         n_bad++; $display("FAIL b2b_busy_len: got %0d expected %0d", cyc - t_fall, 2 * WORD + 1);
      end
      n_cmp++;
      if (rx_q.size() !== 4) begin
         n_bad++; $display("FAIL b2b_rx_count: got %0d expected 4", rx_q.size());
      end else if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h01020304) begin
         n_bad++; $display("FAIL b2b_rx: got %h%h%h%h expected 01020304", rx_q[0], rx_q[1], rx_q[2], rx_q[3]);
      end
      n_cmp++;
      if (rx_t.size() !== 4) begin
         n_bad++; $display("FAIL b2b_gaps: got %0d starts expected 4", rx_t.size());
      end else if (rx_t[1] - rx_t[0] !== 40 || rx_t[2] - rx_t[1] !== 41 || rx_t[3] - rx_t[2] !== 40) begin
         n_bad++; $display("FAIL b2b_gaps: got %0d,%0d,%0d expected 40,41,40",
                           rx_t[1] - rx_t[0], rx_t[2] - rx_t[1], rx_t[3] - rx_t[2]);
      end
   endtask

   task automatic test_overflow();
      int n, f_fall;
      do_reset();
      n = cyc + 1;
      for (int i = 1; i <= 6; i++) begin
         ld_i = 1; data_i = 16'(i);
         @(negedge clk_i);
         n_cmp++;
         if (full_o !== m_full || (i == 5 && full_o !== 1'b1)) begin
            n_bad++; $display("FAIL ovf_full_%0d: got %b expected %b", i, full_o, m_full);
         end
         n_cmp++;
         if (overflow_o !== (i == 6)) begin
            n_bad++; $display("FAIL ovf_flag_%0d: got %b expected %b", i, overflow_o, (i == 6));
         end
      end
      ld_i = 0;
      f_fall = -1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_i);
         if (full_o === 1'b0 && f_fall < 0) f_fall = cyc;
         n_cmp++;
         if ({busy_o, full_o, overflow_o} !== {m_busy, m_full, m_ovf}) begin
            n_bad++; $display("FAIL ovf_flags: got %b expected %b", {busy_o, full_o, overflow_o}, {m_busy, m_full, m_ovf});
         end
         if (busy_o === 1'b0) break;
      end
      n_cmp++;
      if (f_fall !== n + WORD + 2) begin
         n_bad++; $display("FAIL ovf_full_release: got cycle %0d expected %0d", f_fall, n + WORD + 2);
      end
      n_cmp++;
      if (overflow_o !== 1'b1) begin
         n_bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o);
      end
      n_cmp++;
      if (rx_q.size() !== 10) begin
         n_bad++; $display("FAIL ovf_rx_count: got %0d expected 10", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rx_q[2*i], rx_q[2*i+1]} !== 16'(i + 1)) begin
               n_bad++; $display("FAIL ovf_rx_word%0d: got %h%h expected %h", i, rx_q[2*i], rx_q[2*i+1], 16'(i + 1));
            end
         end
      end
   endtask

   task automatic test_simul_pop();
      int n;
      do_reset();
      n = cyc + 1;
      for (int i = 1; i <= 5; i++) begin
         ld_i = 1; data_i = 16'(i);
         @(negedge clk_i);
      end
      ld_i = 0;
      for (int i = 0; i < 200 && cyc < n + WORD + 1; i++) @(negedge clk_i);
      n_cmp++;
      if ({full_o, overflow_o} !== 2'b10) begin
         n_bad++; $display("FAIL simul_before: full,ovf got %b expected 10", {full_o, overflow_o});
      end
      ld_i = 1; data_i = 16'hBEEF;
      @(negedge clk_i);
      ld_i = 0;
      n_cmp++;
      if ({full_o, overflow_o, tx_o} !== 3'b010) begin
         n_bad++; $display("FAIL simul_after: full,ovf,tx got %b expected 010", {full_o, overflow_o, tx_o});
      end
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_i);
         if (busy_o === 1'b0) break;
      end
      n_cmp++;
      if (rx_q.size() !== 10) begin
         n_bad++; $display("FAIL simul_rx_count: got %0d expected 10", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rx_q[2*i], rx_q[2*i+1]} !== 16'(i + 1)) begin
               n_bad++; $display("FAIL simul_rx_word%0d: got %h%h expected %h", i, rx_q[2*i], rx_q[2*i+1], 16'(i + 1));
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      int n;
      logic [15:0] w;
      do_reset();
      w = 16'($urandom);
      w[9] = 1'b0;
      n = cyc + 1;
      strobe(w);
      for (int i = 0; i < 100 && cyc < n + 10; i++) @(negedge clk_i);
      n_cmp++;
      if (tx_o !== 1'b0) begin
         n_bad++; $display("FAIL midframe_bit: tx got %b expected 0 (word %h)", tx_o, w);
      end
      #2 reset_ni = 0;
      #1;
      n_cmp++;
      if ({tx_o, busy_o, full_o, overflow_o} !== 4'b1000) begin
         n_bad++; $display("FAIL midframe_abort: got %b expected 1000", {tx_o, busy_o, full_o, overflow_o});
      end
      repeat (2) @(negedge clk_i);
      reset_ni = 1;
      clear_logs();
      @(negedge clk_i);
      strobe(16'h00FF);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (busy_o === 1'b0) break;
      end
      n_cmp++;
      if (rx_q.size() !== 2) begin
         n_bad++; $display("FAIL midframe_rx_count: got %0d expected 2", rx_q.size());
      end else if ({rx_q[0], rx_q[1]} !== 16'h00FF || frame_err !== 0) begin
         n_bad++; $display("FAIL midframe_rx: got %h%h err %0d expected 00ff err 0", rx_q[0], rx_q[1], frame_err);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 9; k++) begin
         strobe(16'h1000 + 16'(k));
         for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if ({full_o, overflow_o} !== 2'b00) begin
               n_bad++; $display("FAIL wrap_flags: word %0d full,ovf got %b expected 00", k, {full_o, overflow_o});
            end
            if (busy_o === 1'b0) break;
         end
      end
      n_cmp++;
      if (rx_q.size() !== 18) begin
         n_bad++; $display("FAIL wrap_rx_count: got %0d expected 18", rx_q.size());
      end else begin
         for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if ({rx_q[2*k], rx_q[2*k+1]} !== 16'h1000 + 16'(k)) begin
               n_bad++; $display("FAIL wrap_rx_word%0d: got %h%h expected %h", k, rx_q[2*k], rx_q[2*k+1], 16'h1000 + 16'(k));
            end
         end
      end
   endtask

   task automatic test_random();
      int pct;
      do_reset();
      for (int i = 0; i < 2400; i++) begin
         pct = (i < 1200) ? 2 : 6;
         ld_i   = ($urandom_range(0, 99) < pct);
         data_i = 16'($urandom);
         @(negedge clk_i);
         n_cmp++;
         if ({busy_o, full_o, overflow_o} !== {m_busy, m_full, m_ovf}) begin
            n_bad++; $display("FAIL rand_flags: cycle %0d got %b expected %b", cyc, {busy_o, full_o, overflow_o}, {m_busy, m_full, m_ovf});
         end
      end
      ld_i = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_i);
         if (busy_o === 1'b0) break;
      end
      n_cmp++;
      if (busy_o !== 1'b0 || m_busy) begin
         n_bad++; $display("FAIL rand_drain: busy got %b model %b expected 0", busy_o, m_busy);
      end
      n_cmp++;
      if (rx_q.size() !== 2 * exp_w.size() || frame_err !== 0) begin
         n_bad++; $display("FAIL rand_rx_count: got %0d bytes err %0d expected %0d err 0", rx_q.size(), frame_err, 2 * exp_w.size());
      end else begin
         for (int k = 0; k < exp_w.size(); k++) begin
            n_cmp++;
            if ({rx_q[2*k], rx_q[2*k+1]} !== exp_w[k]) begin
               n_bad++; $display("FAIL rand_rx_word%0d: got %h%h expected %h", k, rx_q[2*k], rx_q[2*k+1], exp_w[k]);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_simul_pop();
      test_reset_midframe();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
